// File: rtl/dst_pp_acc_buf.sv
// rtl/dst_pp_acc_buf.sv - ping-pong destination buffer with saturating accumulate
module dst_pp_acc_buf #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          outr,
    input  logic [AW-1:0] oa,
    input  logic [DW-1:0] x,
    input  logic          acc,
    input  logic          swap,
    input  logic          dst_v,
    input  logic [AW-1:0] dst_a,
    output logic [DW-1:0] dst_d,
    output logic          dst_dv,
    output logic          wbank,
    output logic          busy
);

    localparam int DEPTH = 2 ** (AW + 1);
    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    // Both banks share one array; the bank bit is the MSB of the index.
    logic [DW-1:0] mem [DEPTH];

    logic          s1_v;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_x;
    logic          s1_acc;
    logic          s1_bank;

    logic          s2_v;
    logic [AW-1:0] s2_addr;
    logic          s2_bank;
    logic [DW-1:0] s2_res;

    logic          swap_pend;
    logic          swap_req;
    logic          swap_fire;

    logic          fwd;
    logic [DW-1:0] old_val;
    logic [DW:0]   sum;
    logic [DW-1:0] sat_sum;
    logic [DW-1:0] s1_res;

    // S2 holds the only write not yet in memory, so it is the sole forward source.
    always_comb begin
        fwd     = s2_v && (s2_bank == s1_bank) && (s2_addr == s1_addr);
        old_val = fwd ? s2_res : mem[{s1_bank, s1_addr}];
        sum     = {old_val[DW-1], old_val} + {s1_x[DW-1], s1_x};
        sat_sum = sum[DW-1:0];
        if (sum[DW] != sum[DW-1]) begin
            sat_sum = sum[DW] ? SAT_MIN : SAT_MAX;
        end
        s1_res  = s1_acc ? sat_sum : s1_x;
    end

    assign swap_req  = swap_pend | swap;
    assign swap_fire = swap_req & ~s1_v & ~s2_v & ~outr;
    assign busy      = s1_v | s2_v | swap_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_addr   <= '0;
            s1_x      <= '0;
            s1_acc    <= 1'b0;
            s1_bank   <= 1'b0;
            s2_v      <= 1'b0;
            s2_addr   <= '0;
            s2_bank   <= 1'b0;
            s2_res    <= '0;
            swap_pend <= 1'b0;
            wbank     <= 1'b0;
        end else begin
            s1_v <= outr;
            if (outr) begin
                s1_addr <= oa;
                s1_x    <= x;
                s1_acc  <= acc;
                s1_bank <= wbank;
            end
            s2_v <= s1_v;
            if (s1_v) begin
                s2_addr <= s1_addr;
                s2_bank <= s1_bank;
                s2_res  <= s1_res;
            end
            if (swap_fire) begin
                wbank     <= ~wbank;
                swap_pend <= 1'b0;
            end else begin
                swap_pend <= swap_req;
            end
        end
    end

    // Reset clears s2_v asynchronously, so an in-flight write never lands.
    always_ff @(posedge clk) begin
        if (s2_v) begin
            mem[{s2_bank, s2_addr}] <= s2_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_d  <= '0;
            dst_dv <= 1'b0;
        end else begin
            dst_dv <= dst_v;
            if (dst_v) begin
                dst_d <= mem[{~wbank, dst_a}];
            end
        end
    end

endmodule

// File: doc/dst_pp_acc_buf.md
Name: dst_pp_acc_buf

Overview:
- Parametrised ping-pong destination buffer between the compute core result stream and the host readback path.
- Two banks: the core writes one bank, the host reads the other. Roles exchange on a swap request.
- Core writes are either overwrite or read-modify-write accumulate, with signed saturation.
- Writes pass through a 2-stage registered pipeline with same-address forwarding.

Parameters:
- DW, 32, signed fixed-point data width.
- AW, 12, address width; each bank holds 2**AW words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- outr  in  1  core write strobe
- oa  in  AW  core write address
- x  in  DW  core write data, signed
- acc  in  1  1 = accumulate into the existing word, 0 = overwrite
- swap  in  1  request to exchange bank roles (single-cycle pulse)
- dst_v  in  1  host read request
- dst_a  in  AW  host read address
- dst_d  out  DW  host read data
- dst_dv  out  1  host read data valid
- wbank  out  1  bank currently owned by the core; the host reads bank ~wbank
- busy  out  1  write pipeline or a pending swap is active

Behaviour:
- Reset (rst_n low, async): wbank=0, dst_d=0, dst_dv=0, busy=0, swap_pend=0, S1/S2 valid cleared. Memory contents are not reset.
- S1 capture: when outr=1 at an edge, S1 registers {oa, x, acc, wbank} and sets S1 valid.
- S1 compute (combinational):
  - old = mem[S1.bank][S1.addr], unless S2 is valid with the same bank and address; then old = S2.result (forwarding).
  - result = S1.acc ? sat(old + S1.x) : S1.x.
- S2: registers {addr, bank, result} and S2 valid. mem[S2.bank][S2.addr] is written at the end of the S2 cycle.
- Latency: outr at cycle t is written at the end of cycle t+2. It is readable after a swap once busy has dropped.
- Throughput: one write per cycle. Back-to-back accumulates to the same address must sum exactly.
- Saturation:
  - Sum computed in DW+1 bits.
  - Positive overflow -> 2**(DW-1)-1. Negative overflow -> -2**(DW-1).
  - Overwrite mode never saturates.
- Host read:
  - dst_v=1 at cycle t -> dst_d = mem[~wbank][dst_a] and dst_dv=1 during t+1.
  - dst_dv=0 when dst_v was 0; dst_d then holds its last value.
  - The bank is sampled at the dst_v edge, so a read coincident with a swap uses the pre-swap read bank.
- Swap:
  - A swap pulse sets swap_pend.
  - The swap is applied at the first edge where swap_pend=1 and S1 valid=0, S2 valid=0, outr=0. At that edge wbank toggles and swap_pend clears.
  - If outr=0 and the pipeline is already empty in the swap-pulse cycle, the swap applies at that same edge.
  - A swap pulse while swap_pend=1 is absorbed; no double toggle.
  - outr keeps being accepted while a swap is pending; the swap waits for a gap.
- busy = S1 valid | S2 valid | swap_pend.
- Reset mid-operation: in-flight writes are discarded and a pending swap is dropped. A word may retain its pre-write value.
- Host reads never touch the write bank; there is no read/write conflict between the ports.

Test Plan:
- Overwrite, then swap, then read: outr oa=5 x=100 acc=0; swap at t+4; dst_v dst_a=5 -> dst_d=100, dst_dv=1 one cycle later, wbank=1.
- Back-to-back accumulate with forwarding: bank word 7 first overwritten to 10; then three consecutive outr oa=7 acc=1 x=1,2,3; swap and read -> 16.
- Saturation:
  - Word = 0x7FFFFFF0, accumulate x=0x100 -> 0x7FFFFFFF.
  - Word = 0x80000010, accumulate x=-0x100 -> 0x80000000.
- Deferred swap: swap asserted while outr is streaming 4 writes -> wbank unchanged and busy=1 until the stream ends. Toggles exactly once on the first edge with an empty pipeline and outr=0. A second swap pulse during pend causes no extra toggle.
- Ping-pong isolation: core writes bank 1 addr 3 = 55 while the host reads bank 0 addr 3 (prior value 9) -> reads return 9; after swap the read returns 55.
- Async reset mid-pipeline: rst_n low between outr and its S2 edge -> dst_dv=0, busy=0, wbank=0 immediately, without waiting for a clock edge; no later spurious write.
